// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state encoding shared by the UART
//               transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver / transmitter frame-phase encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 50 MHz system clock, 9600 baud
  localparam int UART_CLKS_PER_BIT_9600 = 5208;
  localparam int UART_DATA_BITS         = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-flop synchronizer for the asynchronous serial line plus
//               a registered falling-edge detector. Every flop resets to 1 so
//               that leaving reset on an idle-high line never looks like a
//               start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rxd,
  output logic o_rxd_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_d_q, rxd_d_d;

  // Next values: shift the line into the chain, delay the synchronized bit once more
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_rxd};
    rxd_d_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers, preset to the idle (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      rxd_d_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      rxd_d_q <= rxd_d_d;
    end
  end

  assign o_rxd_s = sync_q[SYNC_STAGES-1];
  assign o_fall  = rxd_d_q & ~sync_q[SYNC_STAGES-1];

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rxd.sv
`default_nettype none
// ============================================================================
// Module      : uart_rxd
// Description : 8N1 UART receiver. Detects the start-bit falling edge,
//               samples every bit at its midpoint with an internal baud
//               counter, and emits a byte with a one-cycle done strobe or a
//               one-cycle framing-error strobe. Returns to IDLE at mid-stop
//               so back-to-back frames are accepted. DATA_BITS must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rxd
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,  // must be >= 16
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int SYNC_STAGES  = 2                         // must be >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rs232_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_rx_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rxd_s;
  logic fall;

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_rxd   (i_rs232_rxd),
    .o_rxd_s (rxd_s),
    .o_fall  (fall)
  );

  // Frame FSM: next state, baud/bit counters, shift register and strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A held-low line gives no fall, so a break never re-arms
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;  // glitch shorter than half a bit
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in from the top leaves it at bit 0
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;
  assign o_rx_busy   = busy_q;

endmodule : uart_rxd
`default_nettype wire

// File: tb/tb_uart_rxd.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rxd
// Description : Self-checking bench for uart_rxd. Frames are driven as serial
//               waveforms; a queue of expected events (byte, good/bad stop,
//               due cycle) is checked against every strobe the receiver
//               produces. A short bit period keeps the run small.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rxd;

  localparam int CLKS  = 64;
  localparam int DBITS = 8;
  localparam int SYNC  = 2;
  localparam int HALF  = CLKS / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rxd = 1'b1;
  logic [DBITS-1:0] o_data;
  logic             o_rx_done;
  logic             o_frame_err;
  logic             o_rx_busy;

  uart_rxd #(
    .CLKS_PER_BIT (CLKS),
    .DATA_BITS    (DBITS),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rs232_rxd (rxd),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_rx_busy   (o_rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected strobe events in order, plus last good byte
  typedef struct {
    logic [7:0] data;
    bit         good;
    int         due;
  } evt_t;
  evt_t       exp_q[$];
  logic [7:0] model_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin : mon
    evt_t ev;
    if (o_rx_done || o_frame_err) begin
      n_checks++;
      assert (!(o_rx_done && o_frame_err)) else begin
        n_errors++;
        $error("FAIL both_strobes: done=%0b err=%0b expected never both", o_rx_done, o_frame_err);
      end
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_strobe: done=%0b err=%0b at cyc %0d expected none", o_rx_done, o_frame_err, cyc);
      end
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check_eq("strobe_kind_done", 32'(o_rx_done), 32'(ev.good));
        n_checks++;
        assert (cyc >= ev.due - 1 && cyc <= ev.due + 1) else begin
          n_errors++;
          $error("FAIL strobe_time: observed cyc=%0d expected %0d +/-1", cyc, ev.due);
        end
        if (ev.good) model_data = ev.data;
        check_eq("o_data_at_strobe", 32'(o_data), 32'(model_data));
      end
    end
  end

  // All drivers start and end at #1 after a rising edge
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit expect_evt);
    logic [9:0] bits;
    int         f;
    bits = {stop_ok, d, 1'b0};
    f    = cyc;
    if (expect_evt)
      exp_q.push_back('{data: d, good: stop_ok, due: f + SYNC + HALF + (DBITS + 1) * CLKS + 1});
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CLKS) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin : stim
    logic [9:0] bits;
    logic [7:0] d;
    bit         ok;
    int         f;

    // Power-up reset, idle line, then a reset pulse
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    idle(200);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_data", 32'(o_data), 32'h0);
    check_eq("rst_done", 32'(o_rx_done), 32'h0);
    check_eq("rst_err", 32'(o_frame_err), 32'h0);
    check_eq("rst_busy", 32'(o_rx_busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    // Single good frame
    send_frame(8'h55, 1'b1, 1'b1);
    idle(CLKS);
    check_eq("data_55", 32'(o_data), 32'h55);
    check_eq("drain_55", 32'(exp_q.size()), 32'h0);
    check_eq("busy_after_55", 32'(o_rx_busy), 32'h0);

    // Back-to-back frames with no idle gap
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(CLKS);
    check_eq("data_b2b", 32'(o_data), 32'hFF);
    check_eq("drain_b2b", 32'(exp_q.size()), 32'h0);

    // Short low glitch: busy until the start sample, then back to idle
    rxd = 1'b0;
    f   = cyc;
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
    wait_cyc(f + SYNC + HALF);
    check_eq("glitch_busy_hi", 32'(o_rx_busy), 32'h1);
    wait_cyc(f + SYNC + HALF + 2);
    check_eq("glitch_busy_lo", 32'(o_rx_busy), 32'h0);
    @(posedge clk);
    #1;
    idle(CLKS);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(CLKS);
    check_eq("data_after_glitch", 32'(o_data), 32'h3C);

    // Good frame, then a framing error, then a long break
    send_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (2000) @(posedge clk);
    #1;
    check_eq("break_busy", 32'(o_rx_busy), 32'h0);
    check_eq("break_data", 32'(o_data), 32'h81);
    check_eq("drain_ferr", 32'(exp_q.size()), 32'h0);
    idle(2 * CLKS);

    // Reset during bit 4 of 0xC7
    bits = {1'b1, 8'hC7, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = bits[i];
      repeat (CLKS) @(posedge clk);
      #1;
    end
    rxd = bits[5];
    repeat (HALF) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_data", 32'(o_data), 32'h0);
    check_eq("midrst_busy", 32'(o_rx_busy), 32'h0);
    check_eq("midrst_done", 32'(o_rx_done), 32'h0);
    check_eq("midrst_err", 32'(o_frame_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_data = 8'h00;
    idle(2 * CLKS);
    check_eq("post_rst_busy", 32'(o_rx_busy), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(CLKS);
    check_eq("data_5A", 32'(o_data), 32'h5A);

    // Random frames, mostly good, random gaps
    for (int n = 0; n < 16; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(9) != 0);
      send_frame(d, ok, 1'b1);
      if (!ok)
        idle(CLKS / 4 + $urandom_range(CLKS));
      else if ($urandom_range(1) == 1)
        idle($urandom_range(3 * CLKS));
    end
    idle(2 * CLKS);
    check_eq("drain_random", 32'(exp_q.size()), 32'h0);
    check_eq("data_random", 32'(o_data), 32'(model_data));
    check_eq("busy_end", 32'(o_rx_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_rxd
`default_nettype wire

// File: doc/uart_rxd.md
Name: uart_rxd

Overview:
UART receiver, the receive-side counterpart of the project's UART transmitter (8N1, LSB first, idle-high line). It samples the asynchronous o_rs232_txd-style serial line at mid-bit using an internal baud counter and reassembles bytes. Each good frame produces a parallel byte plus a one-cycle done strobe, and each bad stop bit produces a framing-error strobe. It sits between the board RS232 pin and user logic, in the same 50 MHz clk domain as the transmitter.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 16.
DATA_BITS, 8, payload bits per frame.
SYNC_STAGES, 2, flops in the input synchronizer; must be >= 2.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  synchronous, active-high reset.
i_rs232_rxd  input  1  asynchronous serial line, idle high.
o_data  output  DATA_BITS  last correctly received byte.
o_rx_done  output  1  one-cycle pulse; o_data is valid from this cycle.
o_frame_err  output  1  one-cycle pulse; stop bit was sampled low.
o_rx_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, counters 0, o_data=0, o_rx_done=0, o_frame_err=0, o_rx_busy=0. The synchronizer flops reset to 1. Reset mid-frame aborts the frame with no strobes.
- i_rs232_rxd passes through SYNC_STAGES flops to give rxd_s, plus one more flop to give rxd_d. fall = rxd_d & ~rxd_s.
- HALF = CLKS_PER_BIT/2 (integer floor). The bit counter counts 0..CLKS_PER_BIT-1.
- IDLE: o_rx_busy=0. On fall, go to START, clear the counter, and set o_rx_busy=1 in the same registered update. A line held low (break) never re-arms; a new fall is required.
- START: at count HALF-1, sample rxd_s.
  - If 0, go to DATA, bit index 0, counter cleared.
  - If 1 (glitch), go to IDLE with no strobe.
- DATA: at count CLKS_PER_BIT-1, shift rxd_s into the shift register MSB side (LSB first on the line) and clear the counter. After bit DATA_BITS-1, go to STOP.
- STOP: at count CLKS_PER_BIT-1, sample rxd_s.
  - If 1: o_data <= shift register, o_rx_done=1 for exactly one cycle, go to IDLE.
  - If 0: o_frame_err=1 for one cycle, o_data unchanged, go to IDLE.
- Sample timing: let t0 be the cycle fall is high. The start bit is sampled at t0+HALF, data bit k at t0+HALF+(k+1)*CLKS_PER_BIT, and the stop bit at t0+HALF+(DATA_BITS+1)*CLKS_PER_BIT. Strobes assert on the cycle after the stop sample.
- Returning to IDLE at mid-stop allows back-to-back frames with no idle gap.
- o_rx_done and o_frame_err are never high together. Both are registered; no output is combinational from i_rs232_rxd.
- o_data holds its value until the next good frame.

Decomposition:
- Shared package/header uart_pkg:
  - state encoding: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - UART_CLKS_PER_BIT_9600=5208
  - UART_DATA_BITS=8
  The transmitter uses the same constants.
- One sub-module, uart_rx_sync: SYNC_STAGES synchronizer plus falling-edge detect. Outputs rxd_s and fall; flops reset to 1.
- FSM, counters and shift register stay in uart_rxd.

Test Plan:
- Idle line high for 10000 cycles, then rst pulse -> all outputs 0, o_rx_busy=0, no strobes.
- Drive 0x55 at CLKS_PER_BIT=5208 (line: 0,1,0,1,0,1,0,1,0,1) -> exactly one o_rx_done, at t0+HALF+9*5208+1 (+/-1 cycle); o_data=8'h55, o_frame_err=0.
- Back-to-back 0xA3, 0x00, 0xFF with zero idle between stop and next start -> three o_rx_done pulses; o_data sequence A3, 00, FF.
- 1000-cycle low glitch on an idle line -> no strobes; o_rx_busy high only until t0+HALF, then 0. A following 0x3C is still received correctly.
- Frame 0x3C with stop bit forced 0, after a prior good 0x81 -> one o_frame_err pulse, no o_rx_done, o_data stays 8'h81. Line then held low 20000 cycles -> no further activity.
- rst asserted during bit 4 of 0xC7 -> next cycle all outputs 0, no strobe. After release, a new 0x5A frame gives o_data=8'h5A.
